uart_tx_framer: RTL and testbench

//  Host-bound UART transmitter for the ODIN FPGA core. Accepts bytes on an AXI-stream-style

---
 rtl/odin_uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_framer.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_framer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/odin_uart_pkg.sv
// Shared UART constants and types for the ODIN core (transmitter and receiver).
//   UART_DATA_BITS  : data bits per frame (8N1)
//   UART_OVERSAMPLE : clk ticks per bit = prescale * UART_OVERSAMPLE
//   uart_state_e    : transmitter FSM states
package odin_uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset, empties the FIFO
//   wr_en_i  : push din_i (accepted when not full, or when a pop happens in the same cycle)
//   din_i    : write data
//   full_o   : no free entry
//   rd_en_i  : pop head (ignored when empty)
//   dout_o   : head entry, valid whenever empty_o is low
//   empty_o  : no entries
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] din_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [Width-1:0] dout_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  // A write into a full FIFO lands in the slot being popped this cycle.
  assign do_wr = wr_en_i && (!full_o || rd_en_i);
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[PtrW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Host-bound 8N1 UART transmitter: byte stream in, FIFO buffered, LSB-first serial out.
//   clk           : core clock
//   rst           : synchronous active-low reset
//   s_axis_tdata  : byte to send
//   s_axis_tvalid : tdata valid
//   s_axis_tready : FIFO can take a byte (low during reset)
//   prescale      : clk cycles per 1/8 bit, sampled at frame start (0 acts as 1)
//   txd           : registered serial line, idle high
//   busy          : registered, high while a frame runs or bytes are queued
module uart_tx_framer
  import odin_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  txd,
  output logic                  busy
);

  // Bit period is prescale * 8, so the timer needs three extra bits.
  localparam int unsigned TmrW = PRESCALE_W + 3;
  localparam logic [TmrW-1:0] TmrOne = {{(TmrW-1){1'b0}}, 1'b1};
  localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [TmrW-1:0]       tmr_q, tmr_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  ready_q;

  logic                  fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [7:0]            fifo_dout;
  logic [PRESCALE_W-1:0] ps_eff;
  logic [TmrW-1:0]       start_reload, run_reload;
  logic                  tmr_last, load;

  assign s_axis_tready = ready_q && !fifo_full;
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .wr_en_i (fifo_wr),
    .din_i   (s_axis_tdata),
    .full_o  (fifo_full),
    .rd_en_i (fifo_rd),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty)
  );

  assign ps_eff       = (prescale == '0) ? {{(PRESCALE_W-1){1'b0}}, 1'b1} : prescale;
  // Start bit uses the live prescale; later bits use the copy latched at frame start.
  assign start_reload = {ps_eff, 3'b000} - TmrOne;
  assign run_reload   = {ps_q, 3'b000} - TmrOne;
  assign tmr_last     = (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ps_d      = ps_q;
    txd_d     = txd_q;
    fifo_rd   = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (tmr_last) begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          tmr_d     = run_reload;
          state_d   = StData;
        end else begin
          tmr_d = tmr_q - TmrOne;
        end
      end
      StData: begin
        if (tmr_last) begin
          tmr_d = run_reload;
          if (bit_idx_q == LastBit) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q - TmrOne;
        end
      end
      StStop: begin
        if (tmr_last) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) load = 1'b1;
          else             state_d = StIdle;
        end else begin
          tmr_d = tmr_q - TmrOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      fifo_rd = 1'b1;
      shift_d = fifo_dout;
      ps_d    = ps_eff;
      tmr_d   = start_reload;
      txd_d   = 1'b0;
      state_d = StStart;
    end

    // Look-ahead: a pop always enters StStart, so FIFO occupancy next cycle only
    // matters when staying idle, where it is non-empty iff it is now or a write lands.
    busy_d = (state_d != StIdle) || !fifo_empty || fifo_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ps_q      <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ps_q      <= ps_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ready_q   <= 1'b1;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic [15:0] prescale;
  logic        txd;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] sb_q[$];
  logic [7:0] tx_q[$];
  int         acc[$];

  uart_tx_framer #(
    .FIFO_DEPTH (4),
    .PRESCALE_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .prescale      (prescale),
    .txd           (txd),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the first n bytes of tx_q through the handshake, logging accept cycles.
  task automatic write_bytes(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      tdata  = tx_q[i];
      tvalid = 1'b1;
      w      = 0;
      while (tready !== 1'b1 && w < 2000) begin
        tick();
        w++;
      end
      if (w >= 2000) begin
        check_eq("wr_timeout", w, 0);
        tvalid = 1'b0;
        return;
      end
      tick();
      sb_q.push_back(tx_q[i]);
      acc.push_back(cyc);
    end
    tvalid = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    while (txd !== 1'b0 && waited < 10000) begin
      tick();
      waited++;
    end
    if (waited >= 10000) check_eq("start_timeout", waited, 0);
  endtask

  // Called on the first start-bit cycle; checks every cycle of the 10-bit frame.
  task automatic check_frame(input logic [7:0] exp, input int bl, input string tag);
    int         errs;
    int         j;
    logic       e;
    logic [7:0] got;
    errs = 0;
    got  = 8'h00;
    for (int c = 0; c < 10 * bl; c++) begin
      j = c / bl;
      if (j == 0)      e = 1'b0;
      else if (j == 9) e = 1'b1;
      else             e = exp[j-1];
      if (txd !== e) errs++;
      if (j >= 1 && j <= 8 && (c % bl) == bl / 2) got[j-1] = txd;
      tick();
    end
    check_eq({tag, "_wave"}, errs, 0);
    check_eq({tag, "_byte"}, got, exp);
  endtask

  task automatic read_frames(input int n, input int bl, input string tag);
    int         w;
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      wait_start(w);
      if (i > 0) check_eq({tag, "_gap"}, w, 0);
      if (sb_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, 0, 1);
        exp = 8'h00;
      end else begin
        exp = sb_q.pop_front();
      end
      check_frame(exp, bl, tag);
    end
  endtask

  initial begin
    int w;
    int zeros;
    logic [7:0] exp;

    // Reset held with tvalid asserted
    rst      = 1'b0;
    tvalid   = 1'b1;
    tdata    = 8'h77;
    prescale = 16'd1;
    repeat (5) tick();
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tready", tready, 0);
    rst    = 1'b1;
    tvalid = 1'b0;
    tick();
    check_eq("rel_tready", tready, 1);
    check_eq("rel_busy", busy, 0);

    // Single byte 0x55
    acc.delete();
    tx_q = '{8'h55};
    write_bytes(1);
    check_eq("t2_busy_on", busy, 1);
    check_eq("t2_txd_pre", txd, 1);
    wait_start(w);
    check_eq("t2_latency", w, 1);
    exp = sb_q.pop_front();
    check_frame(exp, 8, "t2");
    check_eq("t2_busy_off", busy, 0);
    check_eq("t2_len", cyc - acc[0], 81);

    // Back-to-back burst of five
    acc.delete();
    tx_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    fork
      begin
        write_bytes(5);
        check_eq("t3_full_tready", tready, 0);
        check_eq("t3_accept_span", acc[4] - acc[0], 4);
      end
      read_frames(5, 8, "t3");
    join
    check_eq("t3_busy_off", busy, 0);

    // Prescale latch and mid-frame change
    prescale = 16'd54;
    tx_q = '{8'h0F};
    write_bytes(1);
    fork
      begin
        wait_start(w);
        exp = sb_q.pop_front();
        check_frame(exp, 432, "t4a");
      end
      begin
        repeat (1000) tick();
        prescale = 16'd2;
        tx_q = '{8'hA0};
        write_bytes(1);
      end
    join
    read_frames(1, 16, "t4b");
    prescale = 16'd0;
    tx_q = '{8'h96};
    write_bytes(1);
    read_frames(1, 8, "t4c");

    // Reset during data bit 3 of 0xC3 with two bytes queued
    prescale = 16'd1;
    tx_q = '{8'hC3, 8'h11, 8'h22};
    write_bytes(3);
    repeat (34) tick();
    check_eq("t5_bit3", txd, 0);
    rst = 1'b0;
    tick();
    check_eq("t5_rst_txd", txd, 1);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_tready", tready, 0);
    rst = 1'b1;
    sb_q.delete();
    tick();
    zeros = 0;
    repeat (200) begin
      if (txd !== 1'b1) zeros++;
      tick();
    end
    check_eq("t5_quiet", zeros, 0);
    check_eq("t5_busy", busy, 0);

    // Full FIFO with tvalid held: each STOP pop frees a slot next cycle
    acc.delete();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    fork
      write_bytes(7);
      read_frames(7, 8, "t6");
    join
    check_eq("t6_acc5", acc[5] - acc[0], 82);
    check_eq("t6_acc6", acc[6] - acc[0], 162);
    check_eq("t6_sb_left", sb_q.size(), 0);
    check_eq("t6_busy_off", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
